// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the cache/memory arbiter: read-channel FSM state
// encodings, requester indices and the fixed burst length.
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    localparam int REQ_IC      = 0;
    localparam int REQ_DC      = 1;
    localparam int BURST_BEATS = 4;

    // Value the 2-bit beat counter holds while the final beat is on the bus.
    localparam logic [1:0] LAST_BEAT = 2'(BURST_BEATS - 1);

endpackage

// File: rtl/rr_arb2.sv
// Two-way read requester selector.
//   req        in   2  request vector (bit0 icache, bit1 dcache)
//   last_grant in   1  requester that completed the previous burst
//   sel        out  2  one-hot selection, all-zero when nobody requests
// RR_EN=1 alternates on a tie by preferring the requester that is not
// last_grant; RR_EN=0 gives the dcache fixed priority.
module rr_arb2
    import cache_mem_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] sel
);

    always_comb begin
        sel = 2'b00;
        if (req[REQ_IC] && req[REQ_DC]) begin
            if (RR_EN && last_grant)
                sel[REQ_IC] = 1'b1;
            else
                sel[REQ_DC] = 1'b1;
        end else begin
            sel = req;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between the icache (requester 0, read only) and the
// dcache (requester 1, read plus line write-back).
//   clk_g, resetn                       clock, synchronous active-low reset
//   rd_req/rd_addr/rd_rdy               per-requester read request channel
//   ret_valid/ret_last/ret_data         return beats routed to the granted cache
//   wr_req/wr_addr/wr_data/wr_rdy       dcache line write into a 1-entry buffer
//   m_rd_*, m_ret_*, m_wr_*             memory-side read, return and write
//   burst_err                           sticky: a burst ended on a beat other than the 4th
//
// Read FSM
//   state  | meaning
//   R_IDLE | selecting a requester, rd_rdy offered unless a write hazard
//   R_REQ  | presenting latched address on m_rd_*, waiting for m_rd_rdy
//   R_DATA | forwarding memory beats to the granted cache until the last one
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter bit RR_EN      = 1'b1,
    parameter int LINE_OFF_W = 4
) (
    input  logic         clk_g,
    input  logic         resetn,
    input  logic [1:0]   rd_req,
    input  logic [63:0]  rd_addr,
    output logic [1:0]   rd_rdy,
    output logic [1:0]   ret_valid,
    output logic         ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    input  logic [31:0]  wr_addr,
    input  logic [127:0] wr_data,
    output logic         wr_rdy,
    output logic         m_rd_req,
    output logic [31:0]  m_rd_addr,
    input  logic         m_rd_rdy,
    input  logic         m_ret_valid,
    input  logic         m_ret_last,
    input  logic [31:0]  m_ret_data,
    output logic         m_wr_req,
    output logic [31:0]  m_wr_addr,
    output logic [127:0] m_wr_data,
    input  logic         m_wr_rdy,
    output logic         burst_err
);

    rd_state_e    state, state_nxt;
    logic [1:0]   sel;
    logic [31:0]  sel_addr;
    logic         hazard;
    logic         last_grant;
    logic         grant;
    logic [31:0]  rd_addr_q;
    logic [1:0]   beat_cnt;
    logic         wb_valid;
    logic [31:0]  wb_addr;
    logic [127:0] wb_data;

    rr_arb2 #(.RR_EN(RR_EN)) u_arb (
        .req        (rd_req),
        .last_grant (last_grant),
        .sel        (sel)
    );

    assign sel_addr = sel[REQ_DC] ? rd_addr[63:32] : rd_addr[31:0];

    // A write accepted this very cycle counts as already buffered, so a read
    // of the same line cannot overtake it.
    assign hazard = (wb_valid && (sel_addr[31:LINE_OFF_W] == wb_addr[31:LINE_OFF_W]))
                 || (wr_req && wr_rdy && (sel_addr[31:LINE_OFF_W] == wr_addr[31:LINE_OFF_W]));

    assign wr_rdy    = !wb_valid;
    assign m_wr_req  = wb_valid && resetn;
    assign m_wr_addr = wb_addr;
    assign m_wr_data = wb_data;
    assign m_rd_addr = rd_addr_q;

    // Outputs are gated by resetn so nothing leaks in a cycle where reset is
    // asserted but the registers have not yet been cleared.
    always_comb begin
        state_nxt = state;
        rd_rdy    = 2'b00;
        m_rd_req  = 1'b0;
        ret_valid = 2'b00;
        ret_last  = 1'b0;
        ret_data  = '0;
        if (resetn) begin
            case (state)
                R_IDLE: begin
                    rd_rdy = hazard ? 2'b00 : sel;
                    if (|(rd_req & rd_rdy))
                        state_nxt = R_REQ;
                end
                R_REQ: begin
                    m_rd_req = 1'b1;
                    if (m_rd_rdy)
                        state_nxt = R_DATA;
                end
                R_DATA: begin
                    ret_valid[grant] = m_ret_valid;
                    ret_last         = m_ret_last;
                    ret_data         = m_ret_data;
                    if (m_ret_valid && m_ret_last)
                        state_nxt = R_IDLE;
                end
                default: state_nxt = R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_g) begin
        if (!resetn) begin
            state      <= R_IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            rd_addr_q  <= '0;
            beat_cnt   <= '0;
            burst_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == R_IDLE && state_nxt == R_REQ) begin
                rd_addr_q <= sel_addr;
                grant     <= sel[REQ_DC];
            end
            if (state == R_DATA && m_ret_valid) begin
                beat_cnt <= beat_cnt + 2'd1;
                if (m_ret_last) begin
                    last_grant <= grant;
                    if (beat_cnt != LAST_BEAT)
                        burst_err <= 1'b1;
                end
            end
            if (state != R_IDLE && state_nxt == R_IDLE)
                beat_cnt <= '0;
        end
    end

    always_ff @(posedge clk_g) begin
        if (!resetn) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else if (m_wr_req && m_wr_rdy) begin
            wb_valid <= 1'b0;
        end else if (wr_req && wr_rdy) begin
            wb_valid <= 1'b1;
            wb_addr  <= wr_addr;
            wb_data  <= wr_data;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

    logic         clk_g = 1'b0;
    logic         resetn;
    logic [1:0]   rd_req;
    logic [63:0]  rd_addr;
    logic [1:0]   rd_rdy;
    logic [1:0]   ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [31:0]  wr_addr;
    logic [127:0] wr_data;
    logic         wr_rdy;
    logic         m_rd_req;
    logic [31:0]  m_rd_addr;
    logic         m_rd_rdy;
    logic         m_ret_valid;
    logic         m_ret_last;
    logic [31:0]  m_ret_data;
    logic         m_wr_req;
    logic [31:0]  m_wr_addr;
    logic [127:0] m_wr_data;
    logic         m_wr_rdy;
    logic         burst_err;

    logic [1:0]   arb_req;
    logic         arb_last;
    logic [1:0]   sel_rr, sel_fp;

    always #5 clk_g = ~clk_g;

    cache_mem_arbiter #(.RR_EN(1'b1), .LINE_OFF_W(4)) dut (
        .clk_g(clk_g), .resetn(resetn),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
        .m_rd_req(m_rd_req), .m_rd_addr(m_rd_addr), .m_rd_rdy(m_rd_rdy),
        .m_ret_valid(m_ret_valid), .m_ret_last(m_ret_last), .m_ret_data(m_ret_data),
        .m_wr_req(m_wr_req), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data),
        .m_wr_rdy(m_wr_rdy), .burst_err(burst_err)
    );

    rr_arb2 #(.RR_EN(1'b1)) arb_rr (.req(arb_req), .last_grant(arb_last), .sel(sel_rr));
    rr_arb2 #(.RR_EN(1'b0)) arb_fp (.req(arb_req), .last_grant(arb_last), .sel(sel_fp));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_g);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_g);
    endtask

    function automatic logic [31:0] bv(input logic [31:0] a, input int b);
        return a ^ (32'hA5C3_0000 + 32'(b));
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'h0000_1000 | ($urandom_range(3) << 4) | ($urandom_range(3) << 2);
    endfunction

    task automatic idle_inputs();
        rd_req = 2'b00; rd_addr = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        m_rd_rdy = 1'b0; m_ret_valid = 1'b0; m_ret_last = 1'b0; m_ret_data = '0;
        m_wr_rdy = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle_inputs();
        cyc();
        cyc();
        smp();
        chk("rst_m_rd_req", m_rd_req, 0);
        chk("rst_m_wr_req", m_wr_req, 0);
        chk("rst_ret_valid", ret_valid, 0);
        chk("rst_ret_last", ret_last, 0);
        chk("rst_ret_data", ret_data, 0);
        chk("rst_rd_rdy", rd_rdy, 0);
        cyc();
        resetn = 1'b1;
        smp();
        chk("rst_wr_rdy", wr_rdy, 1);
    endtask

    task automatic burst_beats(input logic [1:0] exp_sel, input logic [31:0] a);
        for (int b = 0; b < 4; b++) begin
            cyc();
            m_ret_valid = 1'b1;
            m_ret_data  = bv(a, b);
            m_ret_last  = (b == 3);
            smp();
            chk("beat_valid", ret_valid, exp_sel);
            chk("beat_data", ret_data, bv(a, b));
            chk("beat_last", ret_last, (b == 3));
        end
        cyc();
        m_ret_valid = 1'b0; m_ret_last = 1'b0; m_ret_data = '0;
        smp();
        chk("beat_after", ret_valid, 0);
    endtask

    task automatic read_burst(input logic [1:0] exp_sel, input logic [31:0] a);
        for (int k = 0; k < 20 && rd_rdy == 2'b00; k++) begin
            cyc();
            smp();
        end
        chk("grant", rd_rdy, exp_sel);
        cyc();
        m_rd_rdy = 1'b1;
        smp();
        chk("grant_m_rd_req", m_rd_req, 1);
        chk("grant_m_rd_addr", m_rd_addr, a);
        burst_beats(exp_sel, a);
    endtask

    typedef struct {
        logic [1:0] req;
        logic       last;
        logic [1:0] exp_rr;
        logic [1:0] exp_fp;
    } arb_vec_t;

    typedef struct { logic own; logic [31:0] addr; } rd_t;
    typedef struct { logic [31:0] addr; logic [127:0] data; } wr_t;

    arb_vec_t tbl[8];
    rd_t      issue_q[$];
    wr_t      wq[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] t1_data[4];
        logic        ic_req, dc_req, wr_pend, burst_active, model_last, b_own;
        logic        idle, w_acc, haz, win, mv;
        logic [31:0] ic_addr, dc_addr, wa, b_addr, a;
        logic [127:0] wd;
        logic [1:0]  e_rdy, e_rv;
        int          beat;

        tbl[0] = '{2'b00, 1'b0, 2'b00, 2'b00};
        tbl[1] = '{2'b01, 1'b0, 2'b01, 2'b01};
        tbl[2] = '{2'b01, 1'b1, 2'b01, 2'b01};
        tbl[3] = '{2'b10, 1'b0, 2'b10, 2'b10};
        tbl[4] = '{2'b10, 1'b1, 2'b10, 2'b10};
        tbl[5] = '{2'b11, 1'b0, 2'b10, 2'b10};
        tbl[6] = '{2'b11, 1'b1, 2'b01, 2'b10};
        tbl[7] = '{2'b00, 1'b1, 2'b00, 2'b00};

        for (int i = 0; i < 8; i++) begin
            arb_req  = tbl[i].req;
            arb_last = tbl[i].last;
            #1;
            chk($sformatf("arb_rr[%0d]", i), sel_rr, tbl[i].exp_rr);
            chk($sformatf("arb_fp[%0d]", i), sel_fp, tbl[i].exp_fp);
        end

        // Single icache read
        do_reset();
        t1_data = '{32'h11, 32'h22, 32'h33, 32'h44};
        cyc();
        rd_req = 2'b01; rd_addr[31:0] = 32'h1FC0_0010; m_rd_rdy = 1'b1;
        smp();
        chk("t1_rd_rdy", rd_rdy, 2'b01);
        chk("t1_no_m_rd_yet", m_rd_req, 0);
        cyc();
        rd_req = 2'b00;
        smp();
        chk("t1_m_rd_req", m_rd_req, 1);
        chk("t1_m_rd_addr", m_rd_addr, 32'h1FC0_0010);
        chk("t1_rd_rdy_busy", rd_rdy, 0);
        for (int b = 0; b < 4; b++) begin
            cyc();
            m_ret_valid = 1'b1; m_ret_data = t1_data[b]; m_ret_last = (b == 3);
            smp();
            chk("t1_ret_valid", ret_valid, 2'b01);
            chk("t1_ret_data", ret_data, t1_data[b]);
            chk("t1_ret_last", ret_last, (b == 3));
        end
        cyc();
        m_ret_valid = 1'b0; m_ret_last = 1'b0;
        smp();
        chk("t1_ret_idle", ret_valid, 0);
        chk("t1_burst_err", burst_err, 0);

        // Contention: three bursts with both requesting
        do_reset();
        cyc();
        rd_req = 2'b11; rd_addr = {32'h0000_0200, 32'h0000_0100}; m_rd_rdy = 1'b1;
        smp();
        read_burst(2'b01, 32'h0000_0100);
        read_burst(2'b10, 32'h0000_0200);
        read_burst(2'b01, 32'h0000_0100);

        // Memory backpressure
        do_reset();
        cyc();
        rd_req = 2'b01; rd_addr[31:0] = 32'h0000_0300;
        smp();
        chk("bp_accept", rd_rdy, 2'b01);
        for (int i = 0; i < 10; i++) begin
            cyc();
            rd_req = 2'b11; rd_addr[63:32] = 32'h0000_0400;
            smp();
            chk("bp_m_rd_req", m_rd_req, 1);
            chk("bp_m_rd_addr", m_rd_addr, 32'h0000_0300);
            chk("bp_rd_rdy", rd_rdy, 0);
            chk("bp_ret_valid", ret_valid, 0);
        end
        cyc();
        m_rd_rdy = 1'b1;
        smp();
        chk("bp_release", m_rd_req, 1);
        burst_beats(2'b01, 32'h0000_0300);

        // RAW hazard
        do_reset();
        cyc();
        wr_req = 1'b1; wr_addr = 32'h0000_1230; wr_data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
        smp();
        chk("raw_wr_rdy", wr_rdy, 1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            wr_req = 1'b0;
            rd_req = 2'b10; rd_addr[63:32] = 32'h0000_123C;
            if (i == 3) begin
                rd_req = 2'b11; rd_addr[31:0] = 32'h0000_2000; m_rd_rdy = 1'b1;
            end
            smp();
            chk("raw_m_wr_req", m_wr_req, 1);
            chk("raw_m_wr_addr", m_wr_addr, 32'h0000_1230);
            chk("raw_dc_stall", rd_rdy[1], 0);
            if (i == 3) chk("raw_ic_accept", rd_rdy, 2'b01);
            if (i == 4) chk("raw_ic_m_rd_addr", m_rd_addr, 32'h0000_2000);
        end
        burst_beats(2'b01, 32'h0000_2000);
        chk("raw_still_stall", rd_rdy, 0);
        cyc();
        m_wr_rdy = 1'b1;
        smp();
        chk("raw_drain_stall", rd_rdy, 0);
        cyc();
        m_wr_rdy = 1'b0;
        smp();
        chk("raw_wr_rdy_back", wr_rdy, 1);
        chk("raw_m_wr_done", m_wr_req, 0);
        chk("raw_dc_accept", rd_rdy, 2'b10);
        cyc();
        rd_req = 2'b00;
        smp();
        chk("raw_m_rd_req", m_rd_req, 1);
        chk("raw_m_rd_addr", m_rd_addr, 32'h0000_123C);
        burst_beats(2'b10, 32'h0000_123C);

        // Write buffer full plus same-cycle write-first hazard
        do_reset();
        cyc();
        wr_req = 1'b1; wr_addr = 32'h0000_4000; wr_data = 128'hA;
        rd_req = 2'b10; rd_addr[63:32] = 32'h0000_4008;
        smp();
        chk("wf_wr_rdy", wr_rdy, 1);
        chk("wf_write_first", rd_rdy, 0);
        cyc();
        rd_req = 2'b00;
        wr_addr = 32'h0000_5000; wr_data = 128'hB;
        smp();
        chk("wf_full", wr_rdy, 0);
        chk("wf_first_addr", m_wr_addr, 32'h0000_4000);
        chk("wf_first_data", m_wr_data, 128'hA);
        cyc();
        m_wr_rdy = 1'b1;
        smp();
        chk("wf_full2", wr_rdy, 0);
        chk("wf_drain_addr", m_wr_addr, 32'h0000_4000);
        cyc();
        m_wr_rdy = 1'b0;
        smp();
        chk("wf_rdy_again", wr_rdy, 1);
        chk("wf_empty", m_wr_req, 0);
        cyc();
        wr_req = 1'b0;
        smp();
        chk("wf_second_req", m_wr_req, 1);
        chk("wf_second_addr", m_wr_addr, 32'h0000_5000);
        chk("wf_second_data", m_wr_data, 128'hB);

        // Reset mid-burst
        do_reset();
        cyc();
        wr_req = 1'b1; wr_addr = 32'h0000_7000;
        rd_req = 2'b01; rd_addr[31:0] = 32'h0000_0500; m_rd_rdy = 1'b1;
        smp();
        chk("rm_accept", rd_rdy, 2'b01);
        cyc();
        wr_req = 1'b0; rd_req = 2'b00;
        smp();
        chk("rm_m_rd_req", m_rd_req, 1);
        for (int b = 0; b < 2; b++) begin
            cyc();
            m_ret_valid = 1'b1; m_ret_data = bv(32'h500, b);
            smp();
            chk("rm_beat", ret_valid, 2'b01);
        end
        cyc();
        resetn = 1'b0; m_ret_data = bv(32'h500, 2);
        smp();
        chk("rm_in_reset", ret_valid, 0);
        cyc();
        resetn = 1'b1; m_ret_last = 1'b1; m_ret_data = bv(32'h500, 3);
        smp();
        chk("rm_m_rd_req", m_rd_req, 0);
        chk("rm_m_wr_req", m_wr_req, 0);
        chk("rm_stray", ret_valid, 0);
        chk("rm_wr_rdy", wr_rdy, 1);
        cyc();
        m_ret_valid = 1'b0; m_ret_last = 1'b0;

        // Short burst raises burst_err
        do_reset();
        cyc();
        rd_req = 2'b01; rd_addr[31:0] = 32'h0000_0600; m_rd_rdy = 1'b1;
        smp();
        cyc();
        rd_req = 2'b00;
        smp();
        chk("be_m_rd_req", m_rd_req, 1);
        cyc();
        m_ret_valid = 1'b1; m_ret_data = 32'h1;
        smp();
        cyc();
        m_ret_last = 1'b1; m_ret_data = 32'h2;
        smp();
        chk("be_last", ret_last, 1);
        cyc();
        m_ret_valid = 1'b0; m_ret_last = 1'b0;
        smp();
        chk("be_burst_err", burst_err, 1);

        // Randomized traffic against a transaction-level model
        do_reset();
        ic_req = 0; dc_req = 0; wr_pend = 0; burst_active = 0; model_last = 1;
        ic_addr = '0; dc_addr = '0; wa = '0; wd = '0; b_addr = '0; b_own = 0; beat = 0;
        issue_q.delete();
        wq.delete();
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (!ic_req && $urandom_range(3) == 0) begin ic_req = 1; ic_addr = rand_addr(); end
            if (!dc_req && $urandom_range(3) == 0) begin dc_req = 1; dc_addr = rand_addr(); end
            if (!wr_pend && $urandom_range(5) == 0) begin
                wr_pend = 1; wa = rand_addr(); wd = {$urandom, $urandom, $urandom, $urandom};
            end
            rd_req  = {dc_req, ic_req};
            rd_addr = {dc_addr, ic_addr};
            wr_req  = wr_pend; wr_addr = wa; wr_data = wd;
            m_rd_rdy = 1'($urandom_range(1));
            m_wr_rdy = ($urandom_range(2) == 0);
            if (burst_active) begin
                mv = ($urandom_range(2) != 0);
                m_ret_valid = mv;
                m_ret_data  = mv ? bv(b_addr, beat) : $urandom;
                m_ret_last  = mv && (beat == 3);
            end else begin
                m_ret_valid = ($urandom_range(7) == 0);
                m_ret_data  = $urandom;
                m_ret_last  = 1'($urandom_range(1));
            end
            smp();

            idle  = (issue_q.size() == 0) && !burst_active;
            w_acc = wr_pend && (wq.size() == 0);
            e_rdy = 2'b00;
            win   = 0;
            if (idle && (ic_req || dc_req)) begin
                win = (ic_req && dc_req) ? !model_last : dc_req;
                a   = win ? dc_addr : ic_addr;
                haz = ((wq.size() != 0) && (a[31:4] == wq[0].addr[31:4]))
                   || (w_acc && (a[31:4] == wa[31:4]));
                if (!haz) e_rdy = win ? 2'b10 : 2'b01;
            end
            chk("rnd_rd_rdy", rd_rdy, e_rdy);
            chk("rnd_wr_rdy", wr_rdy, wq.size() == 0);
            chk("rnd_m_wr_req", m_wr_req, wq.size() != 0);
            if (wq.size() != 0) begin
                chk("rnd_m_wr_addr", m_wr_addr, wq[0].addr);
                chk("rnd_m_wr_data", m_wr_data, wq[0].data);
            end
            chk("rnd_m_rd_req", m_rd_req, issue_q.size() != 0);
            if (issue_q.size() != 0) chk("rnd_m_rd_addr", m_rd_addr, issue_q[0].addr);
            e_rv = (burst_active && m_ret_valid) ? (b_own ? 2'b10 : 2'b01) : 2'b00;
            chk("rnd_ret_valid", ret_valid, e_rv);
            if (e_rv != 2'b00) begin
                chk("rnd_ret_data", ret_data, bv(b_addr, beat));
                chk("rnd_ret_last", ret_last, beat == 3);
            end

            if (burst_active && m_ret_valid) begin
                beat++;
                if (beat == 4) begin burst_active = 0; model_last = b_own; end
            end
            if (issue_q.size() != 0 && m_rd_rdy) begin
                b_own = issue_q[0].own; b_addr = issue_q[0].addr;
                beat = 0; burst_active = 1;
                void'(issue_q.pop_front());
            end
            if (e_rdy != 2'b00) begin
                issue_q.push_back('{win, a});
                if (win) dc_req = 0; else ic_req = 0;
            end
            if (wq.size() != 0 && m_wr_rdy) void'(wq.pop_front());
            else if (w_acc) begin wq.push_back('{wa, wd}); wr_pend = 0; end
        end
        chk("rnd_burst_err", burst_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
